// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared types for the EX-stage RV32M multiply/divide sequencer.
// Op encoding follows funct3 so the decoder can pass it through untouched.
package ex_muldiv_sequencer_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } MulDivOp;

  function automatic logic isDiv(MulDivOp op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic isRem(MulDivOp op);
    return op inside {REM, REMU};
  endfunction

  function automatic logic isSignedA(MulDivOp op);
    return op inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic isSignedB(MulDivOp op);
    return op inside {MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand magnitudes, shift-add / restoring-divide iteration and sign fixup.
// Driven by one-hot load/step/fixup strobes from the sequencer FSM.
module muldiv_datapath
  import ex_muldiv_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = ex_muldiv_sequencer_pkg::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  load,
  input  logic                  step,
  input  logic                  fixup,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] dataA,
  input  logic [DATA_WIDTH-1:0] dataB,
  output logic                  special,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  MulDivOp      opIn;
  MulDivOp      opReg;
  logic         signA;
  logic         signB;
  logic         negIn;
  logic         negReg;
  logic [W-1:0] magA;
  logic [W-1:0] magB;
  logic         divByZero;
  logic         overflow;
  logic [W-1:0] specialValue;
  logic [W-1:0] operandReg;
  logic [W-1:0] hiReg;
  logic [W-1:0] loReg;

  logic [W:0]            mulSum;
  logic [W:0]            divShift;
  logic [W:0]            divDiff;
  logic signed [2*W-1:0] product;
  logic signed [2*W-1:0] productFix;
  logic [W-1:0]          quoFix;
  logic [W-1:0]          remFix;
  logic [W-1:0]          fixValue;

  assign opIn  = MulDivOp'(op);
  assign signA = isSignedA(opIn) & dataA[W-1];
  assign signB = isSignedB(opIn) & dataB[W-1];
  assign magA  = signA ? -dataA : dataA;
  assign magB  = signB ? -dataB : dataB;

  // Remainder takes the dividend's sign; everything else the xor of both.
  assign negIn = isRem(opIn) ? signA : (signA ^ signB);

  assign divByZero = isDiv(opIn) && (dataB == '0);
  assign overflow  = ((opIn == DIV) || (opIn == REM)) && (dataA == MOST_NEG) && (dataB == '1);
  assign special   = divByZero | overflow;

  always_comb begin
    specialValue = '0;
    if (divByZero) begin
      specialValue = isRem(opIn) ? dataA : '1;
    end else if (overflow) begin
      specialValue = isRem(opIn) ? '0 : dataA;
    end
  end

  // Multiply: {hi,lo} shifts right with lo holding the unconsumed multiplier bits.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  assign mulSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, operandReg} : '0);
  assign divShift = {hiReg, loReg[W-1]};
  assign divDiff  = divShift - {1'b0, operandReg};

  assign product    = {hiReg, loReg};
  assign productFix = negReg ? -product : product;
  assign quoFix     = negReg ? -loReg : loReg;
  assign remFix     = negReg ? -hiReg : hiReg;

  always_comb begin
    fixValue = productFix[2*W-1:W];
    if (isDiv(opReg)) begin
      fixValue = isRem(opReg) ? remFix : quoFix;
    end else if (opReg == MUL) begin
      fixValue = productFix[W-1:0];
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      opReg      <= MUL;
      negReg     <= 1'b0;
      operandReg <= '0;
      hiReg      <= '0;
      loReg      <= '0;
      result     <= '0;
    end else if (load) begin
      opReg      <= opIn;
      negReg     <= negIn;
      hiReg      <= '0;
      operandReg <= isDiv(opIn) ? magB : magA;
      loReg      <= isDiv(opIn) ? magA : magB;
      if (special) begin
        result <= specialValue;
      end
    end else if (step) begin
      if (isDiv(opReg)) begin
        if (!divDiff[W]) begin
          hiReg <= divDiff[W-1:0];
          loReg <= {loReg[W-2:0], 1'b1};
        end else begin
          hiReg <= divShift[W-1:0];
          loReg <= {loReg[W-2:0], 1'b0};
        end
      end else begin
        {hiReg, loReg} <= {mulSum, loReg[W-1:1]};
      end
    end else if (fixup) begin
      result <= fixValue;
    end
  end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage RV32M sequencer: stalls the pipe while the datapath iterates,
// then presents one result per instruction for a single cycle.
module ex_muldiv_sequencer
  import ex_muldiv_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = ex_muldiv_sequencer_pkg::DATA_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_dataA,
  input  logic [DATA_WIDTH-1:0] i_dataB,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } SeqState;

  SeqState          state;
  SeqState          nextState;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] nextCounter;
  logic             load;
  logic             step;
  logic             fixup;
  logic             special;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= nextState;
      counter <= nextCounter;
    end
  end

  // Flush wins over everything, including a fresh i_valid in IDLE.
  always_comb begin
    nextState   = state;
    nextCounter = counter;
    load        = 1'b0;
    step        = 1'b0;
    fixup       = 1'b0;
    if (i_flush) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            load = 1'b1;
            if (special) begin
              nextState = DONE;
            end else begin
              nextCounter = LAST_STEP;
              nextState   = CALC;
            end
          end
        end
        CALC: begin
          step = 1'b1;
          if (counter == '0) begin
            nextState = FIXUP;
          end else begin
            nextCounter = counter - 1'b1;
          end
        end
        FIXUP: begin
          fixup     = 1'b1;
          nextState = DONE;
        end
        default: begin
          nextState = IDLE;
        end
      endcase
    end
  end

  // Reset gates the stall directly so the pipe is released while reset is held.
  assign o_stall = i_reset & i_valid & (state != DONE) & ~i_flush;
  assign o_valid = (state == DONE) & ~i_flush;

  muldiv_datapath #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_datapath (
    .clock  (i_clock),
    .resetN (i_reset),
    .load   (load),
    .step   (step),
    .fixup  (fixup),
    .op     (i_op),
    .dataA  (i_dataA),
    .dataB  (i_dataB),
    .special(special),
    .result (o_result)
  );

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Bench for ex_muldiv_sequencer: directed literal cases plus random ops,
// all cross-checked every cycle against a latency/arithmetic reference model.
module tb_ex_muldiv_sequencer;

  localparam int W = 32;
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;
  localparam logic [31:0] MOST_NEG = 32'h8000_0000;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_valid = 1'b0;
  logic [2:0]    i_op = 3'd0;
  logic [W-1:0]  i_dataA = '0;
  logic [W-1:0]  i_dataB = '0;
  logic          i_flush = 1'b0;
  logic          o_stall;
  logic          o_valid;
  logic [W-1:0]  o_result;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clock = ~i_clock;

  ex_muldiv_sequencer #(.DATA_WIDTH(W)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_op    (i_op),
    .i_dataA (i_dataA),
    .i_dataB (i_dataB),
    .i_flush (i_flush),
    .o_stall (o_stall),
    .o_valid (o_valid),
    .o_result(o_result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (op)
      OP_MUL:    return a * b;
      OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MOST_NEG && b == 32'hFFFF_FFFF) return a;
        return 32'(int'(a) / int'(b));
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == MOST_NEG && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(int'(a) % int'(b));
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic isDivOp;
    logic fast;
    isDivOp = op[2];
    fast = isDivOp && ((b == 0) ||
           ((op == OP_DIV || op == OP_REM) && a == MOST_NEG && b == 32'hFFFF_FFFF));
    return fast ? 1 : W + 2;
  endfunction

  // Model: one op in flight, result due a fixed number of cycles after acceptance.
  int          cyc = 0;
  bit          pending = 0;
  int          due = 0;
  logic [31:0] pendRes = '0;
  logic [31:0] lastRes = '0;

  always @(negedge i_clock) begin : model
    logic expValid;
    logic expStall;
    logic doneNow;
    doneNow = pending && (due == cyc);
    if (!i_reset) begin
      expValid = 1'b0;
      expStall = 1'b0;
      lastRes  = '0;
      pending  = 0;
    end else begin
      expValid = doneNow && !i_flush;
      expStall = i_valid && !doneNow && !i_flush;
      if (doneNow) lastRes = pendRes;
    end
    check("o_valid", 32'(o_valid), 32'(expValid));
    check("o_stall", 32'(o_stall), 32'(expStall));
    check("o_result", o_result, lastRes);
    if (i_reset) begin
      if (i_flush || doneNow) begin
        pending = 0;
      end else if (!pending && i_valid) begin
        pending = 1;
        due     = cyc + refLatency(i_op, i_dataA, i_dataB);
        pendRes = refResult(i_op, i_dataA, i_dataB);
      end
    end
    cyc++;
  end

  // Issue one op at the current cycle (cycle 0); returns the o_valid cycle or -1.
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int flushAt, output int lat, output logic [31:0] res);
    i_valid = 1'b1;
    i_op    = op;
    i_dataA = a;
    i_dataB = b;
    lat     = -1;
    res     = '0;
    for (int k = 0; k < W + 8; k++) begin
      i_flush = (k == flushAt);
      @(negedge i_clock);
      if (o_valid) begin
        lat = k;
        res = o_result;
        break;
      end
      if (k == flushAt) break;
      @(posedge i_clock);
      #1;
    end
    @(posedge i_clock);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expRes, input int expLat);
    int lat;
    logic [31:0] res;
    runOp(op, a, b, -1, lat, res);
    check({name, " result"}, res, expRes);
    check({name, " latency"}, 32'(lat), 32'(expLat));
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return MOST_NEG;
      3:       return 32'($urandom_range(0, 15));
      4:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int lat;
    logic [31:0] res;
    i_reset = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    i_reset = 1'b1;

    directed("mul 7*-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    directed("mulhu -1*-1", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    directed("mulh -1*-1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    directed("mulhsu -1*-1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    directed("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    directed("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    directed("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
    directed("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
    directed("div 5/0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    directed("rem 5/0", OP_REM, 32'd5, 32'd0, 32'd5, 1);
    directed("div ovf", OP_DIV, MOST_NEG, 32'hFFFF_FFFF, MOST_NEG, 1);
    directed("rem ovf", OP_REM, MOST_NEG, 32'hFFFF_FFFF, 32'd0, 1);

    // Flushed divide must never report; the next op is accepted right after.
    runOp(OP_DIVU, 32'd100, 32'd7, 10, lat, res);
    check("flushed divu seen", 32'(lat), 32'hFFFF_FFFF);
    directed("mul 3*4 after flush", OP_MUL, 32'd3, 32'd4, 32'd12, 34);

    // Reset in the middle of a multiply drops stall/valid/result at once.
    i_valid = 1'b1;
    i_op    = OP_MUL;
    i_dataA = 32'd9;
    i_dataB = 32'd11;
    repeat (15) @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    #1;
    check("reset stall", 32'(o_stall), 32'd0);
    check("reset valid", 32'(o_valid), 32'd0);
    check("reset result", o_result, 32'd0);
    i_valid = 1'b0;
    repeat (2) @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    directed("mul 2*3", OP_MUL, 32'd2, 32'd3, 32'd6, 34);
    directed("mul 5*5", OP_MUL, 32'd5, 32'd5, 32'd25, 34);

    for (int n = 0; n < 250; n++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          flushAt;
      int          expLat;
      logic        expSeen;
      op      = 3'($urandom_range(0, 7));
      a       = randOperand();
      b       = randOperand();
      flushAt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, W + 3)) : -1;
      expLat  = refLatency(op, a, b);
      expSeen = (flushAt < 0) || (flushAt > expLat);
      runOp(op, a, b, flushAt, lat, res);
      check("rand seen", 32'(lat >= 0), 32'(expSeen));
      if (expSeen && lat >= 0) begin
        check("rand latency", 32'(lat), 32'(expLat));
        check("rand result", res, refResult(op, a, b));
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge i_clock);
        #1;
      end
    end

    repeat (2) @(posedge i_clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_sequencer.md
Name: ex_muldiv_sequencer

Overview:
- Multi-cycle sequencer for RV32M multiply/divide ops issued from the EX stage, alongside the single-cycle ALU.
- Captures operands when EX presents an M-extension instruction, stalls the pipeline while it iterates, then returns one result per instruction.
- Multiply uses shift-add and divide uses restoring division, both on operand magnitudes with a final sign-fixup cycle.
- Divide-by-zero and signed overflow take a fast path.

Parameters:
DATA_WIDTH, 32, operand/result width; must equal the shared package DATA_WIDTH.

Ports:
i_clock   input   1           clock, rising edge
i_reset   input   1           reset, asynchronous, active-low
i_valid   input   1           EX holds an M-extension instruction
i_op      input   3           MulDivOp (funct3 encoding)
i_dataA   input   DATA_WIDTH  rs1 value
i_dataB   input   DATA_WIDTH  rs2 value
i_flush   input   1           kill the in-flight op (branch/trap)
o_stall   output  1           hold IF/ID/EX this cycle
o_valid   output  1           o_result valid this cycle
o_result  output  DATA_WIDTH  rd value

Behaviour:
- Reset: state IDLE, counter 0, all operand/accumulator registers 0.
  - o_valid=0, o_result=0, o_stall=0 while i_reset is low.
- o_stall = i_valid & (state != DONE) & ~i_flush. It is combinational so the issuing instruction stays in EX.
- States:
  - IDLE
    - i_valid & ~i_flush: latch op, magnitudes |A| and |B| per signedness, result-sign flags.
    - Special divide case: go to DONE with the fixed result preloaded.
    - Otherwise: counter = DATA_WIDTH-1, go to CALC.
  - CALC
    - One shift-add or restoring-subtract step per cycle; counter decrements.
    - Leave for FIXUP when counter==0, i.e. after exactly DATA_WIDTH cycles.
  - FIXUP
    - Negate the product/quotient/remainder as required.
    - Select the low or high word; go to DONE.
  - DONE
    - o_valid=1, o_result driven, o_stall=0 so the pipeline advances.
    - Next state IDLE unconditionally.
    - o_result holds its value until the next DONE.
- Latency, counting the capture cycle as 0:
  - Normal op: o_valid at cycle DATA_WIDTH+2; o_stall high for cycles 0..DATA_WIDTH+1.
  - Fast path: o_valid at cycle 1.
- Back-to-back ops: the next op is accepted in the IDLE cycle after DONE.
- Multiply:
  - MUL returns the low word.
  - MULH returns the high word, signed×signed.
  - MULHSU returns the high word, signed A × unsigned B.
  - MULHU returns the high word, unsigned×unsigned.
  - Width rule: 2·DATA_WIDTH product; two's-complement negation of the full 2W value when signs differ.
- Divide:
  - Quotient sign = sA^sB (DIV only); remainder sign = sA (REM only).
  - Divisor 0: quotient = all-ones, remainder = dividend.
  - DIV/REM with A = most-negative value and B = -1: quotient = A, remainder = 0.
- Flush:
  - i_flush in any state: next state IDLE, no o_valid; registers may keep stale data.
  - i_flush has priority over i_valid in the same cycle.
- i_valid is sampled only in IDLE. Deasserting it mid-op without a flush is a protocol violation; the op still completes and o_valid pulses.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0.
- Unused encodings: none, because all 8 funct3 values are legal.

Decomposition:
- Shared package (Types) gets:
  - MulDivOp enum, 3-bit, in funct3 order: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Helper predicates isDiv and isSignedA/B as package functions.
- FSM state enum stays local.
- One sub-module, muldiv_datapath: magnitude extraction, shift/accumulate registers, sign fixup.
  - Controlled by load/step/fixup strobes from the FSM held in this block.

Test Plan:
1. MUL 7 × 0xFFFFFFFD (-3) -> o_result 0xFFFFFFEB at cycle 34; o_stall high cycles 0..33, low at 34.
2. A=B=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
4. Fast path, all with o_valid at cycle 1:
   - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
5. DIVU 100/7 started at cycle 0, i_flush at cycle 10 -> no o_valid; state IDLE at cycle 11. MUL 3×4 issued at cycle 11 -> result 12 at cycle 45.
6. i_reset low at cycle 15 of a MUL -> o_stall=0 and o_valid=0 immediately. After release, back-to-back MUL 2×3 then MUL 5×5 -> 6 at cycle 34, 25 at cycle 69.
